// File: rtl/gpio_link_m1_pkg.sv
// -----------------------------------------------------------------------------
// Types_m1 : shared types and field positions for the M1T GPIO link endpoint.
//   link_cmd_t   : command codes carried in gpo[11:8]
//   link_state_t : FSM states of gpio_link_m1
//   GPO_* / GPI_*: bit positions of the gpo command and gpi response fields
//   pack_gpi()   : assembles a response word from its fields
// -----------------------------------------------------------------------------
package Types_m1;

  typedef enum logic [3:0] {
    PUTC   = 4'h1,
    GETC   = 4'h2,
    HALT   = 4'h3,
    STATUS = 4'h4
  } link_cmd_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } link_state_t;

  localparam int GPO_STROBE_BIT = 15;
  localparam int GPO_CMD_HI     = 11;
  localparam int GPO_CMD_LO     = 8;
  localparam int GPO_DATA_HI    = 7;

  localparam int GPI_ACK_BIT    = 15;
  localparam int GPI_ERR_BIT    = 10;
  localparam int GPI_VALID_BIT  = 9;
  localparam int GPI_DATA_HI    = 7;

  // Response word: ack, err, valid and data in place; every other bit is zero.
  function automatic logic [15:0] pack_gpi(input logic       ack,
                                           input logic       err,
                                           input logic       valid,
                                           input logic [7:0] data);
    logic [15:0] w;
    w                     = 16'h0000;
    w[GPI_ACK_BIT]        = ack;
    w[GPI_ERR_BIT]        = err;
    w[GPI_VALID_BIT]      = valid;
    w[GPI_DATA_HI:0]      = data;
    return w;
  endfunction

endpackage

// File: rtl/gpio_link_m1_if.sv
// -----------------------------------------------------------------------------
// gpio_link_m1_if : bundle of the CPU command/response words and the host
// byte streams of the GPIO link endpoint.
//   gpo/gpi                      : command word in, response word out
//   rx_valid/rx_data/rx_ready    : host-to-CPU byte stream (into RX FIFO)
//   tx_valid/tx_data/tx_ready    : CPU-to-host byte stream (single slot)
//   halt/exit_code/timeout       : end-of-test status
// Modports: master = bench/core side, slave = the link endpoint.
// -----------------------------------------------------------------------------
interface gpio_link_m1_if;

  logic [15:0] gpo;
  logic [15:0] gpi;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        halt;
  logic [7:0]  exit_code;
  logic        timeout;

  modport master (
    output gpo,
    input  gpi,
    output rx_valid,
    output rx_data,
    input  rx_ready,
    input  tx_valid,
    input  tx_data,
    output tx_ready,
    input  halt,
    input  exit_code,
    input  timeout
  );

  modport slave (
    input  gpo,
    output gpi,
    input  rx_valid,
    input  rx_data,
    output rx_ready,
    output tx_valid,
    output tx_data,
    input  tx_ready,
    output halt,
    output exit_code,
    output timeout
  );

endinterface

// File: rtl/gpio_link_m1_fifo.sv
// -----------------------------------------------------------------------------
// link_fifo_m1 : synchronous FIFO, first-word fall-through read.
//   clk, sync_rst : clock, synchronous active-high reset (empties the FIFO)
//   push, wdata   : write request and data (ignored when full)
//   pop, rdata    : read request (ignored when empty); rdata shows the head
//   full, empty   : occupancy flags
//   count         : number of stored entries, $clog2(DEPTH)+1 bits
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module link_fifo_m1 #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   sync_rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == CW'(0));
  assign count     = count_q;
  assign rdata     = mem_q[rd_ptr_q];
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  // Next pointers and occupancy; push and pop together leave count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      count_q  <= CW'(0);
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/gpio_link_m1.sv
// -----------------------------------------------------------------------------
// gpio_link_m1 : bench-side endpoint of the M1T GPIO port. Decodes command
// words written on gpo (strobe toggle in [15], cmd in [11:8], data in [7:0]),
// executes them against the host byte streams and answers on gpi
// (ack toggle [15], err [10], valid [9], data [7:0]).
//   clk      : core clock
//   sync_rst : synchronous active-high reset
//   link     : gpio_link_m1_if.slave (gpo/gpi, rx/tx streams, halt,
//              exit_code, timeout)
// Commands: PUTC loads the TX slot (stalls while it is occupied), GETC pops
// the RX FIFO, HALT latches the first exit code, STATUS reports flags.
// Optional feature macro GPIO_LINK_TIMEOUT_EN: idle watchdog that halts the
// test with exit code 0xFF after TIMEOUT_CYCLES idle cycles.
// -----------------------------------------------------------------------------
module gpio_link_m1
  import Types_m1::*;
#(
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic           clk,
  input  logic           sync_rst,
  gpio_link_m1_if.slave  link
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  link_state_t   state_q, state_d;
  logic          seen_tgl_q, seen_tgl_d;
  logic [3:0]    cmd_q, cmd_d;
  logic [7:0]    data_q, data_d;
  logic          resp_err_q, resp_err_d;
  logic          resp_valid_q, resp_valid_d;
  logic [7:0]    resp_data_q, resp_data_d;
  logic [15:0]   gpi_q, gpi_d;
  logic          tx_valid_q, tx_valid_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          halt_q, halt_d;
  logic [7:0]    exit_code_q, exit_code_d;

  logic          strobe_s;
  logic          fifo_push_s;
  logic          fifo_pop_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;
  logic [7:0]    fifo_rdata_s;
  logic [CW-1:0] fifo_count_s;
  logic          fifo_nonempty_s;
  logic          timeout_s;
  logic          to_fire_s;
  logic          unused_gpo_s;

  // A command is pending whenever the strobe differs from the last one taken.
  assign strobe_s        = (link.gpo[GPO_STROBE_BIT] != seen_tgl_q);
  assign fifo_push_s     = link.rx_valid && !fifo_full_s;
  assign fifo_nonempty_s = (fifo_count_s != CW'(0));
  assign unused_gpo_s    = ^link.gpo[14:12];

  link_fifo_m1 #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_rx_fifo (
    .clk      (clk),
    .sync_rst (sync_rst),
    .push     (fifo_push_s),
    .wdata    (link.rx_data),
    .pop      (fifo_pop_s),
    .rdata    (fifo_rdata_s),
    .full     (fifo_full_s),
    .empty    (fifo_empty_s),
    .count    (fifo_count_s)
  );

`ifdef GPIO_LINK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_CYCLES);

  logic [TW-1:0] idle_cnt_q, idle_cnt_d;
  logic          timeout_q, timeout_d;

  // Watchdog: count idle cycles in IDLE until halted, restart on any command.
  always_comb begin
    idle_cnt_d = idle_cnt_q;
    timeout_d  = timeout_q;
    to_fire_s  = 1'b0;
    if ((state_q == IDLE) && strobe_s) begin
      idle_cnt_d = TW'(0);
    end else if ((state_q == IDLE) && !halt_q) begin
      idle_cnt_d = idle_cnt_q + TW'(1);
      if (idle_cnt_d == TO_LIMIT) begin
        timeout_d = 1'b1;
        to_fire_s = 1'b1;
      end else begin
        timeout_d = timeout_q;
        to_fire_s = 1'b0;
      end
    end else begin
      idle_cnt_d = idle_cnt_q;
    end
  end

  // Watchdog registers.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      idle_cnt_q <= TW'(0);
      timeout_q  <= 1'b0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign timeout_s = timeout_q;
`else
  logic unused_cfg_s;
  assign unused_cfg_s = (TIMEOUT_CYCLES < 32'sd1);
  assign to_fire_s    = 1'b0;
  assign timeout_s    = 1'b0;
`endif

  // Command FSM: accept in IDLE, execute in EXEC, publish response in RESP.
  always_comb begin
    state_d      = state_q;
    seen_tgl_d   = seen_tgl_q;
    cmd_d        = cmd_q;
    data_d       = data_q;
    resp_err_d   = resp_err_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    gpi_d        = gpi_q;
    tx_data_d    = tx_data_q;
    halt_d       = halt_q;
    exit_code_d  = exit_code_q;
    fifo_pop_s   = 1'b0;

    // The host drains the TX slot independently of the FSM.
    if (tx_valid_q && link.tx_ready) begin
      tx_valid_d = 1'b0;
    end else begin
      tx_valid_d = tx_valid_q;
    end

    case (state_q)
      IDLE: begin
        if (strobe_s) begin
          seen_tgl_d = link.gpo[GPO_STROBE_BIT];
          cmd_d      = link.gpo[GPO_CMD_HI:GPO_CMD_LO];
          data_d     = link.gpo[GPO_DATA_HI:0];
          state_d    = EXEC;
        end else begin
          state_d    = IDLE;
        end
      end

      EXEC: begin
        resp_err_d   = 1'b0;
        resp_valid_d = 1'b0;
        resp_data_d  = 8'h00;
        case (cmd_q)
          PUTC: begin
            // tx_valid_q is tested, not tx_valid_d, so a load never
            // coincides with the host handshake of the previous byte.
            if (!tx_valid_q) begin
              tx_valid_d   = 1'b1;
              tx_data_d    = data_q;
              resp_valid_d = 1'b1;
              state_d      = RESP;
            end else begin
              state_d      = EXEC;
            end
          end
          GETC: begin
            if (!fifo_empty_s) begin
              fifo_pop_s   = 1'b1;
              resp_valid_d = 1'b1;
              resp_data_d  = fifo_rdata_s;
            end else begin
              resp_valid_d = 1'b0;
              resp_data_d  = 8'h00;
            end
            state_d = RESP;
          end
          HALT: begin
            if (!halt_q) begin
              halt_d      = 1'b1;
              exit_code_d = data_q;
            end else begin
              halt_d      = halt_q;
              exit_code_d = exit_code_q;
            end
            resp_valid_d = 1'b1;
            state_d      = RESP;
          end
          STATUS: begin
            resp_valid_d = 1'b1;
            resp_data_d  = {5'b00000, timeout_s, tx_valid_q, fifo_nonempty_s};
            state_d      = RESP;
          end
          default: begin
            resp_err_d = 1'b1;
            state_d    = RESP;
          end
        endcase
      end

      RESP: begin
        gpi_d   = pack_gpi(seen_tgl_q, resp_err_q, resp_valid_q, resp_data_q);
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Watchdog only fires in IDLE with halt clear, so it never races HALT.
    if (to_fire_s) begin
      halt_d      = 1'b1;
      exit_code_d = 8'hFF;
    end else begin
      halt_d      = halt_d;
      exit_code_d = exit_code_d;
    end
  end

  // FSM and output registers.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state_q      <= IDLE;
      seen_tgl_q   <= 1'b0;
      cmd_q        <= 4'h0;
      data_q       <= 8'h00;
      resp_err_q   <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 8'h00;
      gpi_q        <= 16'h0000;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= 8'h00;
      halt_q       <= 1'b0;
      exit_code_q  <= 8'h00;
    end else begin
      state_q      <= state_d;
      seen_tgl_q   <= seen_tgl_d;
      cmd_q        <= cmd_d;
      data_q       <= data_d;
      resp_err_q   <= resp_err_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      gpi_q        <= gpi_d;
      tx_valid_q   <= tx_valid_d;
      tx_data_q    <= tx_data_d;
      halt_q       <= halt_d;
      exit_code_q  <= exit_code_d;
    end
  end

  assign link.gpi       = gpi_q;
  assign link.rx_ready  = !fifo_full_s;
  assign link.tx_valid  = tx_valid_q;
  assign link.tx_data   = tx_data_q;
  assign link.halt      = halt_q;
  assign link.exit_code = exit_code_q;
  assign link.timeout   = timeout_s;

endmodule

// File: tb/tb_gpio_link_m1.sv
// -----------------------------------------------------------------------------
// tb_gpio_link_m1 : directed bench for gpio_link_m1. Expected response words
// are queued when a command is issued and compared when its ack arrives.
// With GPIO_LINK_TIMEOUT_EN defined the watchdog scenario runs instead of
// the command sequence.
// -----------------------------------------------------------------------------
module tb_gpio_link_m1;

  localparam int DEPTH      = 16;
  localparam int TB_TIMEOUT = 20;

  localparam logic [3:0] C_PUTC   = 4'h1;
  localparam logic [3:0] C_GETC   = 4'h2;
  localparam logic [3:0] C_HALT   = 4'h3;
  localparam logic [3:0] C_STATUS = 4'h4;
  localparam logic [3:0] C_BAD    = 4'hF;

  logic clk;
  logic sync_rst;

  gpio_link_m1_if link_if ();

  gpio_link_m1 #(
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TB_TIMEOUT)
  ) dut (
    .clk      (clk),
    .sync_rst (sync_rst),
    .link     (link_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp;
  int          n_fail;
  logic        tgl;
  logic [7:0]  tb_byte;
  logic [15:0] exp_q [$];
  logic [7:0]  rx_model [$];

  function automatic logic [15:0] resp_word(input logic ack, input logic err,
                                            input logic vld, input logic [7:0] d);
    return {ack, 4'b0000, err, vld, 1'b0, d};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // Toggle the strobe with a new command and queue its expected response.
  task automatic send(input logic [3:0] cmd, input logic [7:0] d,
                      input logic err, input logic vld, input logic [7:0] rd);
    @(negedge clk);
    tgl = ~tgl;
    link_if.gpo = {tgl, 3'b000, cmd, d};
    exp_q.push_back(resp_word(tgl, err, vld, rd));
  endtask

  task automatic wait_ack(input string tag);
    logic [15:0] e;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (link_if.gpi[15] == tgl) break;
    end
    e = exp_q.pop_front();
    check(tag, link_if.gpi, e);
  endtask

  task automatic getc(input string tag);
    logic [7:0] b;
    if (rx_model.size() > 0) begin
      b = rx_model.pop_front();
      send(C_GETC, 8'h00, 1'b0, 1'b1, b);
    end else begin
      send(C_GETC, 8'h00, 1'b0, 1'b0, 8'h00);
    end
    wait_ack(tag);
  endtask

  task automatic push_byte(input logic [7:0] b);
    @(negedge clk);
    check("rx_ready_free", 16'(link_if.rx_ready), 16'h0001);
    link_if.rx_valid = 1'b1;
    link_if.rx_data  = b;
    rx_model.push_back(b);
    @(negedge clk);
    link_if.rx_valid = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: bench did not finish within the time limit");
    $fatal(1, "bench time limit expired");
  end

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    tgl    = 1'b0;
    sync_rst         = 1'b1;
    link_if.gpo      = 16'h0000;
    link_if.rx_valid = 1'b0;
    link_if.rx_data  = 8'h00;
    link_if.tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    sync_rst = 1'b0;

    // Idle after reset: cycles 1..10 after release.
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      check("idle_gpi", link_if.gpi, 16'h0000);
      check("idle_rx_ready", 16'(link_if.rx_ready), 16'h0001);
      check("idle_tx_valid", 16'(link_if.tx_valid), 16'h0000);
      check("idle_halt", 16'(link_if.halt), 16'h0000);
      check("idle_timeout", 16'(link_if.timeout), 16'h0000);
    end
    check("rst_tx_data", 16'(link_if.tx_data), 16'h0000);
    check("rst_exit_code", 16'(link_if.exit_code), 16'h0000);

`ifdef GPIO_LINK_TIMEOUT_EN
    for (int c = 11; c < TB_TIMEOUT; c++) begin
      @(negedge clk);
      check("pre_timeout", {14'h0000, link_if.timeout, link_if.halt}, 16'h0000);
    end
    @(negedge clk);
    check("timeout_flag", 16'(link_if.timeout), 16'h0001);
    check("timeout_halt", 16'(link_if.halt), 16'h0001);
    check("timeout_exit", 16'(link_if.exit_code), 16'h00FF);
    send(C_STATUS, 8'h00, 1'b0, 1'b1, 8'h04);
    wait_ack("status_timeout");
    check("timeout_exit_held", 16'(link_if.exit_code), 16'h00FF);
`else
    // PUTC 0x41 with exact three-edge latency.
    send(C_PUTC, 8'h41, 1'b0, 1'b1, 8'h00);
    @(negedge clk);
    check("putc_lat_k1", link_if.gpi, 16'h0000);
    @(negedge clk);
    check("putc_lat_k2", link_if.gpi, 16'h0000);
    @(negedge clk);
    check("putc_41", link_if.gpi, exp_q.pop_front());
    check("putc_tx_data", 16'(link_if.tx_data), 16'h0041);
    check("putc_tx_valid", 16'(link_if.tx_valid), 16'h0001);

    // Second PUTC stalls until the slot is drained.
    send(C_PUTC, 8'h42, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("putc_stall", link_if.gpi, 16'h8200);
    end
    link_if.tx_ready = 1'b1;
    @(negedge clk);
    link_if.tx_ready = 1'b0;
    wait_ack("putc_42");
    check("putc2_tx_data", 16'(link_if.tx_data), 16'h0042);
    check("putc2_tx_valid", 16'(link_if.tx_valid), 16'h0001);
    @(negedge clk);
    link_if.tx_ready = 1'b1;
    @(negedge clk);
    link_if.tx_ready = 1'b0;
    check("tx_drained", 16'(link_if.tx_valid), 16'h0000);

    // Two RX bytes, three GETCs (the last one on an empty FIFO).
    push_byte(8'h5A);
    push_byte(8'h3C);
    getc("getc_5a");
    getc("getc_3c");
    getc("getc_empty");
    send(C_STATUS, 8'h00, 1'b0, 1'b1, 8'h00);
    wait_ack("status_idle");

    // Fill the FIFO, try an extra push while full, then pop once.
    for (int i = 0; i < DEPTH; i++) push_byte(8'h10 + 8'(i));
    @(negedge clk);
    check("rx_full", 16'(link_if.rx_ready), 16'h0000);
    link_if.rx_valid = 1'b1;
    link_if.rx_data  = 8'hEE;
    repeat (2) @(negedge clk);
    link_if.rx_valid = 1'b0;
    check("rx_full_held", 16'(link_if.rx_ready), 16'h0000);
    send(C_STATUS, 8'h00, 1'b0, 1'b1, 8'h01);
    wait_ack("status_full");
    tb_byte = rx_model.pop_front();
    send(C_GETC, 8'h00, 1'b0, 1'b1, tb_byte);
    @(negedge clk);
    check("full_until_pop", 16'(link_if.rx_ready), 16'h0000);
    @(negedge clk);
    check("rx_ready_after_pop", 16'(link_if.rx_ready), 16'h0001);
    wait_ack("getc_full_first");
    for (int i = 0; i < DEPTH - 1; i++) getc("getc_drain");
    getc("getc_drained_empty");

    // HALT twice (first wins), then an unknown command, then STATUS.
    send(C_HALT, 8'h00, 1'b0, 1'b1, 8'h00);
    wait_ack("halt_00");
    check("halt_set", 16'(link_if.halt), 16'h0001);
    check("halt_exit_00", 16'(link_if.exit_code), 16'h0000);
    send(C_HALT, 8'h07, 1'b0, 1'b1, 8'h00);
    wait_ack("halt_07");
    check("exit_first_wins", 16'(link_if.exit_code), 16'h0000);
    send(C_BAD, 8'h33, 1'b1, 1'b0, 8'h00);
    wait_ack("bad_cmd");
    send(C_STATUS, 8'h00, 1'b0, 1'b1, 8'h00);
    wait_ack("status_after_halt");
    check("no_timeout", 16'(link_if.timeout), 16'h0000);

    // Reset mid-command with strobe high at release.
    push_byte(8'h99);
    @(negedge clk);
    tgl = ~tgl;
    link_if.gpo = {tgl, 3'b000, C_PUTC, 8'h55};
    @(negedge clk);
    sync_rst    = 1'b1;
    tgl         = 1'b1;
    link_if.gpo = {1'b1, 3'b000, C_STATUS, 8'h00};
    rx_model.delete();
    @(negedge clk);
    check("rst_mid_gpi", link_if.gpi, 16'h0000);
    check("rst_mid_tx_valid", 16'(link_if.tx_valid), 16'h0000);
    check("rst_mid_halt", 16'(link_if.halt), 16'h0000);
    check("rst_mid_rx_ready", 16'(link_if.rx_ready), 16'h0001);
    @(negedge clk);
    sync_rst = 1'b0;
    exp_q.push_back(resp_word(1'b1, 1'b0, 1'b1, 8'h00));
    wait_ack("strobe_at_reset");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
